chip8_key_events: RTL and testbench



---
 rtl/chip8_key_events.sv | 123 ++++++++++++
 tb/tb_chip8_key_events.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_key_events.sv
// CHIP-8 keypad debounce, per-key press pulses and the FX0A
// press-then-release wait handshake.
module chip8_key_events #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] key_raw_in,
  output logic [15:0] key_state_out,
  output logic [15:0] key_down_out,
  input  logic        wait_req_in,
  input  logic        cancel_in,
  output logic        wait_busy_out,
  output logic        wait_done_out,
  output logic [3:0]  wait_key_out
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    RELEASE
  } state_e;

  logic [CW-1:0] cnt_q [16];
  logic [15:0]   deb_q;
  logic [15:0]   prev_q;
  logic [15:0]   rise;
  logic [3:0]    rise_idx;
  logic [3:0]    cap_q;
  logic [3:0]    cap_d;
  logic          done_d;
  state_e        state_q;
  state_e        state_d;

  assign key_state_out = deb_q;
  assign rise = deb_q & ~prev_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      deb_q <= '0;
      prev_q <= '0;
      key_down_out <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q <= deb_q;
      key_down_out <= rise;
      for (int i = 0; i < 16; i++) begin
        if (key_raw_in[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i] <= key_raw_in[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Lowest index wins when several keys rise together.
  always_comb begin
    rise_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rise[i]) begin
        rise_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d = cap_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wait_req_in && !cancel_in) begin
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (cancel_in) begin
          state_d = IDLE;
        end else if (|rise) begin
          cap_d = rise_idx;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (cancel_in) begin
          state_d = IDLE;
        end else if (!deb_q[cap_q]) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cap_q <= '0;
      wait_busy_out <= 1'b0;
      wait_done_out <= 1'b0;
      wait_key_out <= '0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      wait_busy_out <= (state_d != IDLE);
      wait_done_out <= done_d;
      if (done_d) begin
        wait_key_out <= cap_q;
      end
    end
  end

endmodule

// File: tb/tb_chip8_key_events.sv
// Bench for chip8_key_events: directed FX0A scenarios plus random
// stimulus, checked every cycle against a behavioural model.
module tb_chip8_key_events;

  localparam int D = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] key_raw_in;
  logic [15:0] key_state_out;
  logic [15:0] key_down_out;
  logic        wait_req_in;
  logic        cancel_in;
  logic        wait_busy_out;
  logic        wait_done_out;
  logic [3:0]  wait_key_out;

  int n_tests = 0;
  int n_fail = 0;

  // model state
  logic [15:0] m_deb, m_prev, m_down;
  int          m_run [16];
  int          m_phase;
  logic [3:0]  m_cap, m_key;
  logic        m_done, m_busy;
  int          down5;
  int          dones;

  chip8_key_events #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .key_raw_in(key_raw_in),
    .key_state_out(key_state_out),
    .key_down_out(key_down_out),
    .wait_req_in(wait_req_in),
    .cancel_in(cancel_in),
    .wait_busy_out(wait_busy_out),
    .wait_done_out(wait_done_out),
    .wait_key_out(wait_key_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_deb = '0;
    m_prev = '0;
    m_down = '0;
    for (int i = 0; i < 16; i++) m_run[i] = 0;
    m_phase = 0;
    m_cap = '0;
    m_key = '0;
    m_done = 1'b0;
    m_busy = 1'b0;
  endtask

  // phase 0 = no wait, 1 = waiting for a fresh press,
  // 2 = waiting for the captured key to be let go
  task automatic model_edge();
    logic [15:0] rose;
    int lo;
    rose = m_deb & ~m_prev;
    m_down = rose;
    m_done = 1'b0;
    lo = -1;
    for (int i = 0; i < 16; i++) begin
      if (rose[i] && lo < 0) lo = i;
    end
    if (m_phase == 0) begin
      if (wait_req_in && !cancel_in) m_phase = 1;
    end else if (cancel_in) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (lo >= 0) begin
        m_cap = 4'(lo);
        m_phase = 2;
      end
    end else if (!m_deb[m_cap]) begin
      m_phase = 0;
      m_done = 1'b1;
      m_key = m_cap;
    end
    m_busy = (m_phase != 0);
    m_prev = m_deb;
    for (int i = 0; i < 16; i++) begin
      if (key_raw_in[i] == m_deb[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] >= D) begin
          m_deb[i] = key_raw_in[i];
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("key_state", key_state_out, m_deb);
    check("key_down", key_down_out, m_down);
    check("busy", 16'(wait_busy_out), 16'(m_busy));
    check("done", 16'(wait_done_out), 16'(m_done));
    check("wait_key", 16'(wait_key_out), 16'(m_key));
    if (key_down_out[5]) down5++;
    if (wait_done_out) dones++;
  endtask

  task automatic step();
    @(posedge clk_in);
    if (rst_n_in) model_edge();
    else model_reset();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_req();
    wait_req_in = 1'b1;
    step();
    wait_req_in = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0;
    key_raw_in = '0;
    wait_req_in = 1'b0;
    cancel_in = 1'b0;
    model_reset();
    down5 = 0;
    dones = 0;
    @(negedge clk_in);
    compare_all();
    rst_n_in = 1'b1;
    steps(3);

    // bounce rejection on key 5
    key_raw_in[5] = 1'b1; step();
    key_raw_in[5] = 1'b0; step();
    key_raw_in[5] = 1'b1; step();
    key_raw_in[5] = 1'b0; step();
    key_raw_in[5] = 1'b1;
    steps(D - 1);
    check("bounce_early", 16'(key_state_out[5]), 16'd0);
    step();
    check("bounce_rise", 16'(key_state_out[5]), 16'd1);
    step();
    check("bounce_pulse", 16'(key_down_out[5]), 16'd1);
    steps(3);
    check("bounce_once", 16'(down5), 16'd1);
    key_raw_in[5] = 1'b0;
    steps(D + 2);

    // basic FX0A on key 0xA
    dones = 0;
    pulse_req();
    check("basic_busy", 16'(wait_busy_out), 16'd1);
    key_raw_in[10] = 1'b1;
    steps(20);
    key_raw_in[10] = 1'b0;
    steps(D);
    check("basic_no_done", 16'(wait_done_out), 16'd0);
    check("basic_still_busy", 16'(wait_busy_out), 16'd1);
    step();
    check("basic_done", 16'(wait_done_out), 16'd1);
    check("basic_key", 16'(wait_key_out), 16'hA);
    check("basic_busy_low", 16'(wait_busy_out), 16'd0);
    // back-to-back request during the done cycle
    pulse_req();
    check("b2b_busy", 16'(wait_busy_out), 16'd1);
    cancel_in = 1'b1; step(); cancel_in = 1'b0;
    steps(2);

    // held key ignored
    dones = 0;
    key_raw_in[3] = 1'b1;
    steps(D + 2);
    pulse_req();
    steps(3);
    key_raw_in[7] = 1'b1;
    steps(D + 3);
    key_raw_in[3] = 1'b0;
    steps(D + 3);
    check("held_no_done", 16'(dones), 16'd0);
    key_raw_in[7] = 1'b0;
    steps(D + 1);
    check("held_done", 16'(wait_done_out), 16'd1);
    check("held_key", 16'(wait_key_out), 16'd7);
    steps(2);

    // simultaneous press of 2 and 9
    dones = 0;
    pulse_req();
    key_raw_in[2] = 1'b1;
    key_raw_in[9] = 1'b1;
    steps(D + 3);
    key_raw_in[9] = 1'b0;
    steps(D + 3);
    check("simul_no_done", 16'(dones), 16'd0);
    key_raw_in[2] = 1'b0;
    steps(D + 1);
    check("simul_done", 16'(wait_done_out), 16'd1);
    check("simul_key", 16'(wait_key_out), 16'd2);
    steps(2);

    // cancel while in RELEASE
    dones = 0;
    pulse_req();
    key_raw_in[12] = 1'b1;
    steps(D + 3);
    cancel_in = 1'b1;
    step();
    cancel_in = 1'b0;
    check("cancel_busy", 16'(wait_busy_out), 16'd0);
    key_raw_in[12] = 1'b0;
    steps(D + 4);
    check("cancel_no_done", 16'(dones), 16'd0);
    pulse_req();
    check("cancel_fresh", 16'(wait_busy_out), 16'd1);
    key_raw_in[1] = 1'b1;
    steps(D + 3);

    // async reset mid-RELEASE, key 4 held through it
    key_raw_in[1] = 1'b0;
    key_raw_in[4] = 1'b1;
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check("rst_state", key_state_out, 16'd0);
    check("rst_down", key_down_out, 16'd0);
    check("rst_busy", 16'(wait_busy_out), 16'd0);
    check("rst_done", 16'(wait_done_out), 16'd0);
    check("rst_key", 16'(wait_key_out), 16'd0);
    steps(2);
    rst_n_in = 1'b1;
    steps(D - 1);
    check("rst_k4_early", 16'(key_state_out[4]), 16'd0);
    step();
    check("rst_k4_rise", 16'(key_state_out[4]), 16'd1);
    step();
    check("rst_k4_pulse", 16'(key_down_out[4]), 16'd1);
    key_raw_in = '0;
    steps(D + 2);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        key_raw_in[$urandom_range(0, 15)] ^= 1'b1;
      end
      wait_req_in = ($urandom_range(0, 7) == 0);
      cancel_in = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
